// File: rtl/serial_digit_adder_if.sv
// Start/busy/done handshake bundle for serial_digit_adder.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_digit_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf;

   modport master (output start, a, b, cin, input busy, done, result, cout, ovf);
   modport slave  (input start, a, b, cin, output busy, done, result, cout, ovf);
`else
   modport master (output start, a, b, cin, input busy, done, result, cout);
   modport slave  (input start, a, b, cin, output busy, done, result, cout);
`endif
endinterface

// File: rtl/serial_digit_adder.sv
// Multi-cycle WIDTH-bit adder processing two bits per clock through a 2-bit
// full-adder slice. Optional signed overflow output via SERIAL_ADD_OVF_EN.

// 2-bit full adder digit slice.
module two_bit_full_adder (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       cin,
   output logic [1:0] sum,
   output logic       cout
);
   // Three-bit sum of two digits plus carry.
   always_comb begin
      {cout, sum} = 3'(a) + 3'(b) + 3'(cin);
   end
endmodule

module serial_digit_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   serial_digit_adder_if.slave   bus
);
   localparam int unsigned DIGITS = WIDTH / 2;
   localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [WIDTH-1:0]   op_a, op_a_n;
   logic [WIDTH-1:0]   op_b, op_b_n;
   logic               carry_reg, carry_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [WIDTH-1:0]   acc, acc_n;
   logic [WIDTH-1:0]   result_q, result_n;
   logic               cout_q, cout_n;
   logic               busy_q, busy_n;
   logic               done_q, done_n;

   logic [1:0]         slice_sum;
   logic               slice_cout;
   logic [WIDTH+1:0]   acc_cat;
   logic [WIDTH-1:0]   acc_shift;
   logic               last_digit;

`ifdef SERIAL_ADD_OVF_EN
   logic               a_msb, a_msb_n;
   logic               b_msb, b_msb_n;
   logic               ovf_q, ovf_n;
`endif

   two_bit_full_adder u_slice (
      .a    (op_a[1:0]),
      .b    (op_b[1:0]),
      .cin  (carry_reg),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // New digit enters at the top of the accumulator; the concat form also covers WIDTH=2.
   always_comb begin
      acc_cat    = {slice_sum, acc};
      acc_shift  = acc_cat[WIDTH+1:2];
      last_digit = (cnt == CNT_W'(DIGITS - 1));
   end

   // Next-state and next-register logic.
   always_comb begin
      state_n  = state;
      op_a_n   = op_a;
      op_b_n   = op_b;
      carry_n  = carry_reg;
      cnt_n    = cnt;
      acc_n    = acc;
      result_n = result_q;
      cout_n   = cout_q;
      busy_n   = busy_q;
      done_n   = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      a_msb_n  = a_msb;
      b_msb_n  = b_msb;
      ovf_n    = ovf_q;
`endif
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               state_n = RUN;
               op_a_n  = bus.a;
               op_b_n  = bus.b;
               carry_n = bus.cin;
               cnt_n   = '0;
               acc_n   = '0;
               busy_n  = 1'b1;
`ifdef SERIAL_ADD_OVF_EN
               a_msb_n = bus.a[WIDTH-1];
               b_msb_n = bus.b[WIDTH-1];
`endif
            end
         end
         RUN: begin
            acc_n   = acc_shift;
            carry_n = slice_cout;
            op_a_n  = op_a >> 2;
            op_b_n  = op_b >> 2;
            cnt_n   = cnt + CNT_W'(1);
            if (last_digit) begin
               state_n  = DONE;
               busy_n   = 1'b0;
               done_n   = 1'b1;
               result_n = acc_shift;
               cout_n   = slice_cout;
`ifdef SERIAL_ADD_OVF_EN
               ovf_n    = (a_msb == b_msb) && (acc_shift[WIDTH-1] != a_msb);
`endif
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_a      <= '0;
         op_b      <= '0;
         carry_reg <= 1'b0;
         cnt       <= '0;
         acc       <= '0;
         result_q  <= '0;
         cout_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
         ovf_q     <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         op_a      <= op_a_n;
         op_b      <= op_b_n;
         carry_reg <= carry_n;
         cnt       <= cnt_n;
         acc       <= acc_n;
         result_q  <= result_n;
         cout_q    <= cout_n;
         busy_q    <= busy_n;
         done_q    <= done_n;
`ifdef SERIAL_ADD_OVF_EN
         a_msb     <= a_msb_n;
         b_msb     <= b_msb_n;
         ovf_q     <= ovf_n;
`endif
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.cout   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign bus.ovf    = ovf_q;
`endif

endmodule

// File: doc/serial_digit_adder.md
# serial_digit_adder

- Multi-cycle adder that adds two WIDTH-bit operands two bits per clock.
- Instantiates `two_bit_full_adder` as its single digit slice and sits directly upstream of it.
- Feeds the slice one operand digit pair plus a registered carry each cycle, and collects the slice's sum and carry into a WIDTH-bit result.
- Gives the FPGA designs wide additions from the existing 2-bit LUT adder, using a start/busy/done handshake.

## Interface
- `WIDTH`, 8, operand/result width in bits; must be even and ≥ 2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  operand A, unsigned (or two's complement with OVF feature).
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry into digit 0.
- `busy`  out  1  high while digits are being processed (RUN).
- `done`  out  1  one-cycle pulse; `result`/`cout` are valid from this cycle.
- `result`  out  WIDTH  sum bits.
- `cout`  out  1  carry out of the top digit.
- `ovf`  out  1  signed overflow; present only with `SERIAL_ADD_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE:**
  - `start`=1 at an edge loads `a`, `b` into shift registers.
  - The same edge sets carry_reg←`cin`, clears the digit counter and moves to RUN.
  - `start`=0 stays in IDLE.
- **RUN, each edge:**
  - The slice receives the low 2 bits of each shift register and carry_reg.
  - Slice `sum` is shifted into the top of the accumulator.
  - carry_reg←slice `Cout`.
  - Operand registers shift right by 2.
  - The counter increments.
- RUN → DONE on the edge that processes digit WIDTH/2−1. On that same edge:
  - `result`←final accumulator (including the last digit).
  - `cout`←final slice `Cout`.
- **DONE:** the next edge always returns to IDLE.
- `start` is ignored in RUN and DONE; no queueing.
- Operand inputs are sampled only at the accepting edge; later changes have no effect.
- `result`/`cout`/`ovf` hold their last completed value until the next completion. They never show partial sums.
- Arithmetic: {`cout`,`result`} = `a` + `b` + `cin`, exact, no truncation.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `cout`=0, `ovf`=0, internal registers 0.
- `rst` has priority over `start` at the same edge.
- Reset mid-RUN or in DONE aborts the operation and clears all outputs at that edge.
- The accepting edge is E0.
- `busy`=1 from E0 until E(WIDTH/2); that is WIDTH/2 cycles.
- `done`=1 between E(WIDTH/2) and E(WIDTH/2+1).
- Earliest next acceptance is E(WIDTH/2+2), i.e. `start` sampled in IDLE.
- Throughput is one operation per WIDTH/2+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- WIDTH=2: one RUN cycle. `done` follows the edge after acceptance.

## Configuration
- `SERIAL_ADD_OVF_EN` defined:
  - Adds port `ovf`.
  - At the RUN→DONE edge, `ovf`←(a[WIDTH−1]==b[WIDTH−1]) && (sum[WIDTH−1]!=a[WIDTH−1]), using the captured operand MSBs.
  - `ovf` holds with `result` and resets to 0.
- Not defined:
  - No `ovf` port and no overflow logic.
  - All other behaviour is identical.

## Test plan
- WIDTH=8, `a`=0x5A, `b`=0x3C, `cin`=0, `start` pulse → `busy` for 4 cycles, then `done`=1 for 1 cycle with `result`=0x96, `cout`=0.
- `a`=0xFF, `b`=0x01, `cin`=0 → `result`=0x00, `cout`=1. Then `a`=0xFF, `b`=0xFF, `cin`=1 → `result`=0xFF, `cout`=1.
- Busy and held behaviour:
  - During RUN, assert `start` with `a`=0x11, `b`=0x22 and change `a`/`b` each cycle → ignored; the in-flight sum completes unchanged.
  - `result` keeps its prior value until `done`.
- Reset:
  - Assert `rst` at the second RUN cycle → `busy`=0, `done`=0, `result`=0, `cout`=0 next cycle.
  - A following `a`=0x01, `b`=0x01 operation → `result`=0x02.
- Same-edge priority: `rst` and `start` high at the same edge → remains IDLE, `busy`=0.
- With `SERIAL_ADD_OVF_EN`: 0x7F+0x01 → `result`=0x80, `ovf`=1, `cout`=0; 0x80+0x80 → `result`=0x00, `cout`=1, `ovf`=1; 0x40+0x20 → `ovf`=0.
